// File: rtl/prt_pkg.sv
// Shared types for the PRT scheduler: FSM states, pending-verdict queue entry
// and a saturating counter helper.
package prt_pkg;

   // Slot field width for the default 10-slot PRT; length covers up to 2047 bytes.
   localparam int PRT_SLOT_W = 4;
   localparam int PRT_LEN_W  = 11;

   typedef enum logic [2:0] {
      IDLE, WR_START, WR_DATA, WR_FIN, RD_START, RD_DATA, INV, INV_WAIT
   } prt_sched_state_t;

   typedef struct packed {
      logic [PRT_SLOT_W-1:0] slot;
      logic [PRT_LEN_W-1:0]  len;
   } prt_q_entry_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/prt_sched_fifo.sv
// Pending-verdict queue: one entry per packet written to the PRT and still
// waiting for a classifier verdict. Head is visible combinationally.
module prt_sched_fifo
   import prt_pkg::*;
#(
   parameter int DEPTH = 10
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       push_i,
   input  prt_q_entry_t               data_i,
   input  logic                       pop_i,
   output prt_q_entry_t               head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   prt_q_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          push_ok, pop_ok;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Storage array: no reset needed, occupancy is tracked by count_q.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= nxt(wr_ptr_q);
         if (pop_ok)  rd_ptr_q <= nxt(rd_ptr_q);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/prt_scheduler.sv
// PRT scheduler: serialises ingress writes, verdict-driven reads/invalidates
// and the post-invalidate quiet period onto the single-transaction PRT.
module prt_scheduler
   import prt_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SLOTS  = 10,
   parameter int MAX_LEN    = 1518,
   parameter int INV_CYCLES = 1520
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [DATA_WIDTH-1:0]        in_data_i,
   input  logic                         in_last_i,
   input  logic                         vd_valid_i,
   output logic                         vd_ready_o,
   input  logic                         vd_drop_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [DATA_WIDTH-1:0]        out_data_o,
   output logic                         out_last_o,
   input  logic                         prt_slot_free_i,
   output logic                         prt_start_wr_en_o,
   input  logic                         prt_start_wr_rdy_i,
   input  logic [$clog2(NUM_SLOTS)-1:0] prt_start_wr_slot_i,
   output logic                         prt_wr_en_o,
   input  logic                         prt_wr_rdy_i,
   output logic [DATA_WIDTH-1:0]        prt_wr_data_o,
   output logic                         prt_fin_wr_en_o,
   input  logic                         prt_fin_wr_rdy_i,
   output logic                         prt_start_rd_en_o,
   input  logic                         prt_start_rd_rdy_i,
   output logic [$clog2(NUM_SLOTS)-1:0] prt_start_rd_slot_o,
   output logic                         prt_rd_en_o,
   input  logic                         prt_rd_rdy_i,
   input  logic [DATA_WIDTH:0]          prt_rd_data_i,
   output logic                         prt_inv_en_o,
   input  logic                         prt_inv_rdy_i,
   output logic [$clog2(NUM_SLOTS)-1:0] prt_inv_slot_o,
   output logic [15:0]                  drop_count_o,
   output logic [15:0]                  trunc_count_o
);

   localparam int SW = $clog2(NUM_SLOTS);
   localparam int WW = $clog2(INV_CYCLES+1);
   localparam logic [PRT_LEN_W-1:0] LEN_MAX = PRT_LEN_W'(MAX_LEN);

   prt_sched_state_t      state_q;
   logic [SW-1:0]         slot_q, rd_slot_q, inv_slot_q;
   logic [PRT_LEN_W-1:0]  len_q, cnt_q;
   logic                  first_q, trunc_q;
   logic                  sw_en_q, fw_en_q, sr_en_q, inv_en_q;
   logic                  out_valid_q, out_last_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic [WW-1:0]         wait_q;
   logic [15:0]           drop_q, trunc_cnt_q;

   prt_q_entry_t          q_head, q_din;
   logic                  q_push, q_pop, q_full, q_empty;
   logic [$clog2(NUM_SLOTS+1)-1:0] q_count;
   logic                  wr_beat, out_fire, verdict;
   logic                  unused_sig;

   // The PRT end marker is redundant with the stored length; occupancy is
   // only needed as full/empty here.
   assign unused_sig = ^{prt_rd_data_i[DATA_WIDTH], q_count};

   assign wr_beat  = (state_q == WR_DATA) && in_valid_i && prt_wr_rdy_i;
   assign out_fire = out_valid_q && out_ready_i;
   assign verdict  = (state_q == IDLE) && vd_valid_i && !q_empty;

   assign in_ready_o    = (state_q == WR_DATA) && prt_wr_rdy_i;
   assign vd_ready_o    = (state_q == IDLE) && !q_empty;
   assign prt_wr_en_o   = wr_beat && (len_q < LEN_MAX);
   assign prt_wr_data_o = prt_wr_en_o ? in_data_i : '0;
   assign prt_rd_en_o   = (state_q == RD_DATA) && prt_rd_rdy_i &&
                          (cnt_q < q_head.len) && (!out_valid_q || out_ready_i);

   assign prt_start_wr_en_o   = sw_en_q;
   assign prt_fin_wr_en_o     = fw_en_q;
   assign prt_start_rd_en_o   = sr_en_q;
   assign prt_inv_en_o        = inv_en_q;
   assign prt_start_rd_slot_o = rd_slot_q;
   assign prt_inv_slot_o      = inv_slot_q;
   assign out_valid_o         = out_valid_q;
   assign out_data_o          = out_data_q;
   assign out_last_o          = out_last_q;
   assign drop_count_o        = drop_q;
   assign trunc_count_o       = trunc_cnt_q;

   // Drops pop on verdict acceptance; forwards pop once the last byte leaves.
   assign q_push = (state_q == WR_FIN) && prt_fin_wr_rdy_i;
   assign q_pop  = (verdict && vd_drop_i) ||
                   ((state_q == RD_DATA) && out_fire && out_last_q);
   assign q_din  = '{slot: PRT_SLOT_W'(slot_q), len: len_q};

   prt_sched_fifo #(.DEPTH(NUM_SLOTS)) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (q_push),
      .data_i  (q_din),
      .pop_i   (q_pop),
      .head_o  (q_head),
      .full_o  (q_full),
      .empty_o (q_empty),
      .count_o (q_count)
   );

   // Scheduler FSM with registered PRT requests and egress stage.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         rd_slot_q   <= '0;
         inv_slot_q  <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         first_q     <= 1'b0;
         trunc_q     <= 1'b0;
         sw_en_q     <= 1'b0;
         fw_en_q     <= 1'b0;
         sr_en_q     <= 1'b0;
         inv_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         wait_q      <= '0;
         drop_q      <= '0;
         trunc_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (verdict) begin
                  if (vd_drop_i) begin
                     inv_slot_q <= SW'(q_head.slot);
                     inv_en_q   <= 1'b1;
                     drop_q     <= sat_inc(drop_q);
                     state_q    <= INV;
                  end else begin
                     rd_slot_q  <= SW'(q_head.slot);
                     sr_en_q    <= 1'b1;
                     state_q    <= RD_START;
                  end
               end else if (in_valid_i && prt_slot_free_i && !q_full) begin
                  sw_en_q <= 1'b1;
                  state_q <= WR_START;
               end
            end
            WR_START: begin
               if (prt_start_wr_rdy_i) begin
                  sw_en_q <= 1'b0;
                  first_q <= 1'b1;
                  len_q   <= '0;
                  trunc_q <= 1'b0;
                  state_q <= WR_DATA;
               end
            end
            WR_DATA: begin
               if (first_q) begin
                  slot_q  <= prt_start_wr_slot_i;
                  first_q <= 1'b0;
               end
               if (wr_beat) begin
                  if (len_q < LEN_MAX) len_q <= len_q + PRT_LEN_W'(1);
                  else                 trunc_q <= 1'b1;
                  if (in_last_i) begin
                     if (trunc_q || len_q == LEN_MAX) trunc_cnt_q <= sat_inc(trunc_cnt_q);
                     fw_en_q <= 1'b1;
                     state_q <= WR_FIN;
                  end
               end
            end
            WR_FIN: begin
               if (prt_fin_wr_rdy_i) begin
                  fw_en_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RD_START: begin
               if (prt_start_rd_rdy_i) begin
                  sr_en_q <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (prt_rd_en_o) begin
                  out_data_q  <= prt_rd_data_i[DATA_WIDTH-1:0];
                  out_valid_q <= 1'b1;
                  cnt_q       <= cnt_q + PRT_LEN_W'(1);
                  out_last_q  <= ((cnt_q + PRT_LEN_W'(1)) == q_head.len);
               end else if (out_fire) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (out_last_q) begin
                     inv_slot_q <= SW'(q_head.slot);
                     inv_en_q   <= 1'b1;
                     state_q    <= INV;
                  end
               end
            end
            INV: begin
               if (prt_inv_rdy_i) begin
                  inv_en_q <= 1'b0;
                  wait_q   <= WW'(INV_CYCLES-1);
                  state_q  <= INV_WAIT;
               end
            end
            INV_WAIT: begin
               if (wait_q == '0) state_q <= IDLE;
               else              wait_q  <= wait_q - WW'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prt_scheduler.sv
// Directed bench for prt_scheduler with a small behavioural PRT responder.
module tb_prt_scheduler;

   localparam int INV_CYC = 1520;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, in_last;
   logic [7:0] in_data;
   logic       vd_valid, vd_ready, vd_drop;
   logic       out_valid, out_ready, out_last;
   logic [7:0] out_data;
   logic       prt_slot_free;
   logic       prt_start_wr_en, prt_start_wr_rdy;
   logic [3:0] prt_start_wr_slot;
   logic       prt_wr_en, prt_wr_rdy;
   logic [7:0] prt_wr_data;
   logic       prt_fin_wr_en, prt_fin_wr_rdy;
   logic       prt_start_rd_en, prt_start_rd_rdy;
   logic [3:0] prt_start_rd_slot;
   logic       prt_rd_en, prt_rd_rdy;
   logic [8:0] prt_rd_data;
   logic       prt_inv_en, prt_inv_rdy;
   logic [3:0] prt_inv_slot;
   logic [15:0] drop_count, trunc_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   prt_scheduler #(.DATA_WIDTH(8), .NUM_SLOTS(10), .MAX_LEN(1518), .INV_CYCLES(INV_CYC)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
      .vd_valid_i(vd_valid), .vd_ready_o(vd_ready), .vd_drop_i(vd_drop),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
      .prt_slot_free_i(prt_slot_free),
      .prt_start_wr_en_o(prt_start_wr_en), .prt_start_wr_rdy_i(prt_start_wr_rdy),
      .prt_start_wr_slot_i(prt_start_wr_slot),
      .prt_wr_en_o(prt_wr_en), .prt_wr_rdy_i(prt_wr_rdy), .prt_wr_data_o(prt_wr_data),
      .prt_fin_wr_en_o(prt_fin_wr_en), .prt_fin_wr_rdy_i(prt_fin_wr_rdy),
      .prt_start_rd_en_o(prt_start_rd_en), .prt_start_rd_rdy_i(prt_start_rd_rdy),
      .prt_start_rd_slot_o(prt_start_rd_slot),
      .prt_rd_en_o(prt_rd_en), .prt_rd_rdy_i(prt_rd_rdy), .prt_rd_data_i(prt_rd_data),
      .prt_inv_en_o(prt_inv_en), .prt_inv_rdy_i(prt_inv_rdy), .prt_inv_slot_o(prt_inv_slot),
      .drop_count_o(drop_count), .trunc_count_o(trunc_count)
   );

   // PRT responder: each request is acked with a one-cycle pulse the cycle after it is seen.
   logic        sw_ack, fw_ack, sr_ack, iv_ack;
   logic [3:0]  wslot, rslot;
   logic [10:0] wptr, rptr;
   logic [7:0]  pmem [16][2048];

   assign prt_start_wr_rdy = sw_ack;
   assign prt_fin_wr_rdy   = fw_ack;
   assign prt_start_rd_rdy = sr_ack;
   assign prt_inv_rdy      = iv_ack;
   assign prt_rd_data      = {1'b0, pmem[rslot][rptr]};

   always @(posedge clk) begin
      if (!rst_n) begin
         sw_ack <= 1'b0; fw_ack <= 1'b0; sr_ack <= 1'b0; iv_ack <= 1'b0;
         wslot <= '0; rslot <= '0; wptr <= '0; rptr <= '0;
      end else begin
         sw_ack <= prt_start_wr_en && !sw_ack;
         fw_ack <= prt_fin_wr_en && !fw_ack;
         sr_ack <= prt_start_rd_en && !sr_ack;
         iv_ack <= prt_inv_en && !iv_ack;
         if (prt_start_wr_en && sw_ack) begin wslot <= prt_start_wr_slot; wptr <= '0; end
         if (prt_wr_en) begin pmem[wslot][wptr] <= prt_wr_data; wptr <= wptr + 11'd1; end
         if (prt_start_rd_en && sr_ack) begin rslot <= prt_start_rd_slot; rptr <= '0; end
         if (prt_rd_en) rptr <= rptr + 11'd1;
      end
   end

   // Transaction monitor: counts handshakes and captures egress bytes.
   logic       clr_mon;
   int         wr_cnt, sw_cnt, fin_cnt, sr_cnt, rd_cnt, inv_cnt, eg_cnt, last_cnt, last_idx;
   logic [3:0] rd_slot_seen, inv_slot_seen;
   logic [7:0] eg_mem [2048];

   always @(posedge clk) begin
      if (clr_mon) begin
         wr_cnt <= 0; sw_cnt <= 0; fin_cnt <= 0; sr_cnt <= 0; rd_cnt <= 0;
         inv_cnt <= 0; eg_cnt <= 0; last_cnt <= 0; last_idx <= -1;
         rd_slot_seen <= '0; inv_slot_seen <= '0;
      end else if (rst_n) begin
         if (prt_wr_en) wr_cnt <= wr_cnt + 1;
         if (prt_start_wr_en && sw_ack) sw_cnt <= sw_cnt + 1;
         if (prt_fin_wr_en && fw_ack) fin_cnt <= fin_cnt + 1;
         if (prt_start_rd_en && sr_ack) begin sr_cnt <= sr_cnt + 1; rd_slot_seen <= prt_start_rd_slot; end
         if (prt_rd_en) rd_cnt <= rd_cnt + 1;
         if (prt_inv_en && iv_ack) begin inv_cnt <= inv_cnt + 1; inv_slot_seen <= prt_inv_slot; end
         if (out_valid && out_ready) begin
            eg_mem[eg_cnt[10:0]] <= out_data;
            eg_cnt <= eg_cnt + 1;
            if (out_last) begin last_cnt <= last_cnt + 1; last_idx <= eg_cnt; end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      @(negedge clk); clr_mon = 1'b1;
      @(negedge clk); clr_mon = 1'b0;
   endtask

   task automatic send_pkt(input int n, input logic [7:0] base, output int stalls, output int to);
      int b;
      stalls = 0; to = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = base + 8'(i); in_last = (i == n-1);
         #1; b = 0;
         while (!in_ready && b < 5000) begin @(negedge clk); #1; b++; end
         if (b >= 5000) begin to = 1; break; end
         if (i > 0) stalls += b;
      end
      @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_vd(input logic drop, input string tag);
      int b;
      @(negedge clk); vd_valid = 1'b1; vd_drop = drop;
      #1; b = 0;
      while (!vd_ready && b < 5000) begin @(negedge clk); #1; b++; end
      chk(tag, (b >= 5000), 0);
      @(negedge clk); vd_valid = 1'b0; vd_drop = 1'b0;
   endtask

   task automatic wait_inv(input int n, input string tag);
      int b = 0;
      while (inv_cnt != n && b < 20000) begin @(negedge clk); b++; end
      chk(tag, inv_cnt, n);
   endtask

   function automatic int eg_bad(input int n, input logic [7:0] base);
      int bad = 0;
      for (int k = 0; k < n; k++) if (eg_mem[k] !== base + 8'(k)) bad++;
      return bad;
   endfunction

   initial begin
      int st, to, n, b;
      logic [9:0]  ctl;
      logic [23:0] dat;

      rst_n = 1'b0; clr_mon = 1'b1;
      in_valid = 0; in_data = '0; in_last = 0; vd_valid = 0; vd_drop = 0;
      out_ready = 1'b1; prt_slot_free = 1'b1; prt_wr_rdy = 1'b1; prt_rd_rdy = 1'b1;
      prt_start_wr_slot = 4'd0;
      repeat (3) @(negedge clk);
      ctl = {prt_start_wr_en, prt_wr_en, prt_fin_wr_en, prt_start_rd_en, prt_rd_en,
             prt_inv_en, in_ready, vd_ready, out_valid, out_last};
      chk("rst_ctl", ctl, 0);
      dat = {prt_start_rd_slot, prt_inv_slot, out_data, prt_wr_data};
      chk("rst_data", dat, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_trunc", trunc_count, 0);
      rst_n = 1'b1; clr_mon = 1'b0;

      // 1: 4-byte forward into slot 3
      prt_start_wr_slot = 4'd3;
      send_pkt(4, 8'hA0, st, to);
      chk("t1_in_to", to, 0);
      repeat (4) @(negedge clk);
      chk("t1_wr_cnt", wr_cnt, 4);
      chk("t1_fin_cnt", fin_cnt, 1);
      chk("t1_vd_ready", vd_ready, 1);
      send_vd(1'b0, "t1_vd_to");
      wait_inv(1, "t1_inv");
      chk("t1_eg_cnt", eg_cnt, 4);
      chk("t1_eg_data", {eg_mem[0], eg_mem[1], eg_mem[2], eg_mem[3]}, 32'hA0A1A2A3);
      chk("t1_last_idx", last_idx, 3);
      chk("t1_last_cnt", last_cnt, 1);
      chk("t1_rd_slot", rd_slot_seen, 3);
      chk("t1_inv_slot", inv_slot_seen, 3);
      repeat (INV_CYC + 4) @(negedge clk);

      // 2: drop, slot 5
      clear_mon();
      prt_start_wr_slot = 4'd5;
      send_pkt(3, 8'h10, st, to);
      chk("t2_in_to", to, 0);
      repeat (4) @(negedge clk);
      send_vd(1'b1, "t2_vd_to");
      wait_inv(1, "t2_inv");
      chk("t2_rd_start", sr_cnt, 0);
      chk("t2_inv_slot", inv_slot_seen, 5);
      chk("t2_drop", drop_count, 1);
      chk("t2_eg_cnt", eg_cnt, 0);
      repeat (INV_CYC + 4) @(negedge clk);

      // 3: 1600-byte packet truncated to 1518
      clear_mon();
      prt_start_wr_slot = 4'd7;
      send_pkt(1600, 8'h00, st, to);
      chk("t3_in_to", to, 0);
      chk("t3_in_stall", st, 0);
      repeat (4) @(negedge clk);
      chk("t3_wr_cnt", wr_cnt, 1518);
      chk("t3_trunc", trunc_count, 1);
      send_vd(1'b0, "t3_vd_to");
      wait_inv(1, "t3_inv");
      chk("t3_eg_cnt", eg_cnt, 1518);
      chk("t3_eg_bad", eg_bad(1518, 8'h00), 0);
      chk("t3_last_idx", last_idx, 1517);
      chk("t3_last_cnt", last_cnt, 1);
      repeat (INV_CYC + 4) @(negedge clk);

      // 4: 64-byte forward with out_ready toggling every cycle
      clear_mon();
      prt_start_wr_slot = 4'd2;
      send_pkt(64, 8'h40, st, to);
      chk("t4_in_to", to, 0);
      repeat (4) @(negedge clk);
      send_vd(1'b0, "t4_vd_to");
      b = 0;
      while (inv_cnt != 1 && b < 2000) begin @(negedge clk); out_ready = ~out_ready; b++; end
      out_ready = 1'b1;
      chk("t4_inv", inv_cnt, 1);
      chk("t4_eg_cnt", eg_cnt, 64);
      chk("t4_rd_cnt", rd_cnt, 64);
      chk("t4_eg_bad", eg_bad(64, 8'h40), 0);
      chk("t4_last_idx", last_idx, 63);
      repeat (INV_CYC + 4) @(negedge clk);

      // 5: verdict and ingress together; verdict wins
      prt_start_wr_slot = 4'd4;
      send_pkt(2, 8'h55, st, to);
      chk("t5_in_to", to, 0);
      repeat (4) @(negedge clk);
      clear_mon();
      @(negedge clk);
      vd_valid = 1'b1; vd_drop = 1'b1; in_valid = 1'b1; in_data = 8'h66; in_last = 1'b1;
      #1;
      chk("t5_vd_ready", vd_ready, 1);
      chk("t5_in_ready", in_ready, 0);
      @(negedge clk); vd_valid = 1'b0; vd_drop = 1'b0;
      wait_inv(1, "t5_inv");
      chk("t5_no_wr", sw_cnt, 0);
      chk("t5_inv_slot", inv_slot_seen, 4);
      chk("t5_drop", drop_count, 2);
      // INV_CYC cycles in INV_WAIT, one in IDLE, then the write request rises
      n = 0;
      while (!prt_start_wr_en && n < 5000) begin @(negedge clk); n++; end
      chk("t5_wr_delay", n, INV_CYC + 1);
      #1; b = 0;
      while (!in_ready && b < 100) begin @(negedge clk); #1; b++; end
      chk("t5_wr_to", (b >= 100), 0);
      @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
      repeat (4) @(negedge clk);

      // 6: reset in the middle of a read
      clear_mon();
      send_vd(1'b1, "t6_vd0_to");
      wait_inv(1, "t6_inv");
      repeat (INV_CYC + 4) @(negedge clk);
      prt_start_wr_slot = 4'd6;
      send_pkt(20, 8'h80, st, to);
      chk("t6_in_to", to, 0);
      repeat (4) @(negedge clk);
      send_vd(1'b0, "t6_vd_to");
      b = 0;
      while (eg_cnt != 10 && b < 500) begin @(negedge clk); b++; end
      chk("t6_eg10", eg_cnt, 10);
      chk("t6_pre_valid", out_valid, 1);
      chk("t6_pre_drop", drop_count, 3);
      rst_n = 1'b0;
      @(negedge clk);
      ctl = {prt_start_wr_en, prt_wr_en, prt_fin_wr_en, prt_start_rd_en, prt_rd_en,
             prt_inv_en, in_ready, vd_ready, out_valid, out_last};
      chk("t6_rst_ctl", ctl, 0);
      chk("t6_rst_drop", drop_count, 0);
      chk("t6_rst_trunc", trunc_count, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6_q_empty", vd_ready, 0);
      chk("t6_idle_rd", prt_start_rd_en, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
